// File: rtl/dmem_write_buffer_if.sv
// Pipeline-side and memory-side signals of the MEM-stage write buffer.
interface dmem_write_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // pipeline side
    logic          MemRead_i;
    logic          MemWrite_i;
    logic [31:0]   addr_i;
    logic [31:0]   data_i;
    logic [31:0]   data_o;
    logic          stall_o;
    // backing memory side
    logic          mem_req_o;
    logic          mem_we_o;
    logic [31:0]   mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;
    logic          mem_ack_i;
    // occupancy
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          empty_o;

    modport slave (
        input  MemRead_i, MemWrite_i, addr_i, data_i, mem_rdata_i, mem_ack_i,
        output data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               count_o, full_o, empty_o
    );

    modport master (
        output MemRead_i, MemWrite_i, addr_i, data_i, mem_rdata_i, mem_ack_i,
        input  data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               count_o, full_o, empty_o
    );
endinterface

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer for the MEM stage: stores are queued and drained in the
// background, loads forward from the youngest queued store or read memory.
module dmem_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_write_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WR, RD, RDONE} state_t;

    state_t        state;
    logic [29:0]   q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [PW-1:0] head, tail, idx;
    logic [CW-1:0] count, count_nxt;
    logic          full, empty;
    logic [31:0]   rdata_q;
    logic          mem_req, mem_we;
    logic [31:0]   mem_addr, mem_wdata;
    logic          load, store, push, pop, hit, miss;
    logic [31:0]   fwd_data;
    logic [1:0]    unused_addr_bits;

    assign unused_addr_bits = bus.addr_i[1:0];

    // a combined read+write request is a load; its store half is dropped
    assign load  = bus.MemRead_i;
    assign store = bus.MemWrite_i && !bus.MemRead_i;
    assign push  = store && !full;
    assign pop   = (state == WR) && bus.mem_ack_i;
    // in RDONE the pending load is being answered from rdata_q
    assign miss  = load && !hit && (state != RDONE);

    // youngest-match search: scan oldest to youngest so later matches win
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && q_addr[idx] == bus.addr_i[31:2]) begin
                hit      = 1'b1;
                fwd_data = q_data[idx];
            end
        end
    end

    // next occupancy from simultaneous push/pop
    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    // entry storage; contents beyond count are don't-care so no reset needed
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_addr[tail] <= bus.addr_i[31:2];
            q_data[tail] <= bus.data_i;
        end
    end

    // pointers and registered occupancy flags
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // memory port FSM; request/address/data are held from assertion until ack
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        state    <= RD;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {bus.addr_i[31:2], 2'b00};
                    end else if (!empty) begin
                        state     <= WR;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {q_addr[head], 2'b00};
                        mem_wdata <= q_data[head];
                    end
                end
                WR: begin
                    if (bus.mem_ack_i) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                RD: begin
                    if (bus.mem_ack_i) begin
                        state   <= RDONE;
                        mem_req <= 1'b0;
                        rdata_q <= bus.mem_rdata_i;
                    end
                end
                RDONE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_o      = (load && hit && state != RDONE) ? fwd_data : rdata_q;
    assign bus.stall_o     = miss || (store && full);
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.count_o     = count;
    assign bus.full_o      = full;
    assign bus.empty_o     = empty;
endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer with a small handshaked memory model.
module tb_dmem_write_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_write_buffer_if #(.DEPTH(DEPTH)) bus ();
    dmem_write_buffer #(.DEPTH(DEPTH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    // memory model: ack after ack_delay wait cycles, unless held off
    logic [31:0] mem [256];
    logic [31:0] wr_log [$];
    int          rd_cnt = 0;
    int          wcnt = 0;
    int          ack_delay = 0;
    int          max_cnt = 0;
    logic        ack_hold = 1'b0;
    logic        force_ack = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    assign bus.mem_rdata_i = mem[bus.mem_addr_o[9:2]];
    assign bus.mem_ack_i   = force_ack | (bus.mem_req_o & ~ack_hold & (wcnt >= ack_delay));

    always @(posedge clk) begin
        if (!rst || !bus.mem_req_o || bus.mem_ack_i) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (rst && bus.mem_req_o && bus.mem_ack_i) begin
            if (bus.mem_we_o) begin
                mem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
                wr_log.push_back(bus.mem_addr_o);
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end
        if (rst && int'(bus.count_o) > max_cnt) max_cnt <= int'(bus.count_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.MemRead_i  = rd;
        bus.MemWrite_i = wr;
        bus.addr_i     = a;
        bus.data_i     = d;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (!(bus.empty_o && !bus.mem_req_o) && n < bound) begin
            cyc();
            smp();
            n++;
        end
        chk("drain_done", 32'(bus.empty_o && !bus.mem_req_o), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_w [5];
        int          rd0;
        int          n0;
        exp_w = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h20] = 32'hDEADBEEF;   // word 0x80
        mem[8'h21] = 32'h12345678;   // word 0x84
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        // reset held for two edges
        rst = 1'b0;
        cyc(); cyc();
        smp();
        chk("rst_data",  bus.data_o, 32'h0);
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_req",   32'(bus.mem_req_o), 32'd0);
        chk("rst_we",    32'(bus.mem_we_o), 32'd0);
        chk("rst_addr",  bus.mem_addr_o, 32'h0);
        chk("rst_wdata", bus.mem_wdata_o, 32'h0);
        chk("rst_count", 32'(bus.count_o), 32'd0);
        chk("rst_full",  32'(bus.full_o), 32'd0);
        chk("rst_empty", 32'(bus.empty_o), 32'd1);
        cyc(); rst = 1'b1;

        // posted stores with 3 wait cycles, then a store while full
        ack_delay = 3;
        cyc(); drive(1'b0, 1'b1, 32'h10, 32'hA); smp();
        chk("ps1_stall", 32'(bus.stall_o), 32'd0);
        cyc(); drive(1'b0, 1'b1, 32'h14, 32'hB); smp();
        chk("ps2_stall", 32'(bus.stall_o), 32'd0);
        chk("ps2_count", 32'(bus.count_o), 32'd1);
        cyc(); drive(1'b0, 1'b1, 32'h18, 32'hC); smp();
        chk("ps3_stall", 32'(bus.stall_o), 32'd0);
        chk("ps3_req",   32'(bus.mem_req_o), 32'd1);
        chk("ps3_addr",  bus.mem_addr_o, 32'h10);
        chk("ps3_wdata", bus.mem_wdata_o, 32'hA);
        cyc(); drive(1'b0, 1'b1, 32'h1C, 32'hD); smp();
        chk("ps4_stall", 32'(bus.stall_o), 32'd0);
        chk("ps4_count", 32'(bus.count_o), 32'd3);
        cyc(); drive(1'b0, 1'b1, 32'h20, 32'hE); smp();
        chk("fs1_full",  32'(bus.full_o), 32'd1);
        chk("fs1_count", 32'(bus.count_o), 32'd4);
        chk("fs1_stall", 32'(bus.stall_o), 32'd1);
        cyc(); smp();
        chk("fs2_stall", 32'(bus.stall_o), 32'd1);
        cyc(); smp();
        chk("fs3_stall", 32'(bus.stall_o), 32'd0);
        chk("fs3_full",  32'(bus.full_o), 32'd0);
        chk("fs3_count", 32'(bus.count_o), 32'd3);
        cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0); smp();
        chk("fs4_count", 32'(bus.count_o), 32'd4);
        chk("fs4_full",  32'(bus.full_o), 32'd1);
        wait_drain(200);
        chk("ps_nwr", 32'(wr_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("ps_order%0d", i),
                (i < wr_log.size()) ? wr_log[i] : 32'hFFFFFFFF, exp_w[i]);
        chk("ps_mem20", mem[8'h08], 32'hE);
        chk("ps_maxcnt", 32'(max_cnt), 32'd4);

        // forwarding from youngest entry, then a miss behind an outstanding write
        ack_hold = 1'b1;
        ack_delay = 0;
        rd0 = rd_cnt;
        cyc(); drive(1'b0, 1'b1, 32'h40, 32'h1); smp();
        chk("fw1_stall", 32'(bus.stall_o), 32'd0);
        cyc(); drive(1'b0, 1'b1, 32'h40, 32'h2); smp();
        chk("fw2_count", 32'(bus.count_o), 32'd1);
        cyc(); drive(1'b1, 1'b0, 32'h40, 32'h0); smp();
        chk("fw3_data",  bus.data_o, 32'h2);
        chk("fw3_stall", 32'(bus.stall_o), 32'd0);
        chk("fw3_we",    32'(bus.mem_we_o), 32'd1);
        chk("fw3_count", 32'(bus.count_o), 32'd2);
        cyc(); drive(1'b1, 1'b0, 32'h84, 32'h0); smp();
        chk("mw1_stall", 32'(bus.stall_o), 32'd1);
        cyc(); ack_hold = 1'b0; smp();
        chk("mw2_stall", 32'(bus.stall_o), 32'd1);
        cyc(); smp();
        chk("mw3_stall", 32'(bus.stall_o), 32'd1);
        chk("mw3_req",   32'(bus.mem_req_o), 32'd0);
        chk("mw3_count", 32'(bus.count_o), 32'd1);
        cyc(); smp();
        chk("mw4_stall", 32'(bus.stall_o), 32'd1);
        chk("mw4_we",    32'(bus.mem_we_o), 32'd0);
        chk("mw4_addr",  bus.mem_addr_o, 32'h84);
        cyc(); smp();
        chk("mw5_stall", 32'(bus.stall_o), 32'd0);
        chk("mw5_data",  bus.data_o, 32'h12345678);
        cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0); smp();
        chk("mw6_rdcnt", 32'(rd_cnt), 32'(rd0 + 1));
        wait_drain(100);
        chk("fw_mem40", mem[8'h10], 32'h2);
        chk("fw_nwr",   32'(wr_log.size()), 32'd7);

        // load miss with empty buffer and zero-wait memory
        rd0 = rd_cnt;
        cyc(); drive(1'b1, 1'b0, 32'h80, 32'h0); smp();
        chk("lm1_stall", 32'(bus.stall_o), 32'd1);
        chk("lm1_req",   32'(bus.mem_req_o), 32'd0);
        cyc(); smp();
        chk("lm2_stall", 32'(bus.stall_o), 32'd1);
        chk("lm2_req",   32'(bus.mem_req_o), 32'd1);
        chk("lm2_we",    32'(bus.mem_we_o), 32'd0);
        chk("lm2_addr",  bus.mem_addr_o, 32'h80);
        cyc(); smp();
        chk("lm3_stall", 32'(bus.stall_o), 32'd0);
        chk("lm3_data",  bus.data_o, 32'hDEADBEEF);
        cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0); smp();
        chk("lm4_data",  bus.data_o, 32'hDEADBEEF);
        chk("lm4_req",   32'(bus.mem_req_o), 32'd0);
        chk("lm4_rdcnt", 32'(rd_cnt), 32'(rd0 + 1));

        // read and write together: load wins, store dropped
        cyc(); drive(1'b1, 1'b1, 32'h84, 32'h55); smp();
        chk("rw1_stall", 32'(bus.stall_o), 32'd1);
        cyc(); smp();
        chk("rw2_stall", 32'(bus.stall_o), 32'd1);
        cyc(); smp();
        chk("rw3_data",  bus.data_o, 32'h12345678);
        cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0); smp();
        chk("rw4_count", 32'(bus.count_o), 32'd0);
        chk("rw4_empty", 32'(bus.empty_o), 32'd1);

        // reset while a write is outstanding
        ack_hold = 1'b1;
        n0 = wr_log.size();
        cyc(); drive(1'b0, 1'b1, 32'h100, 32'h1); smp();
        cyc(); drive(1'b0, 1'b1, 32'h104, 32'h2); smp();
        cyc(); drive(1'b0, 1'b1, 32'h108, 32'h3); smp();
        chk("rm3_req",  32'(bus.mem_req_o), 32'd1);
        chk("rm3_addr", bus.mem_addr_o, 32'h100);
        cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0); rst = 1'b0; smp();
        chk("rm4_count", 32'(bus.count_o), 32'd3);
        cyc(); rst = 1'b1; smp();
        chk("rm5_req",   32'(bus.mem_req_o), 32'd0);
        chk("rm5_count", 32'(bus.count_o), 32'd0);
        chk("rm5_empty", 32'(bus.empty_o), 32'd1);
        chk("rm5_data",  bus.data_o, 32'h0);
        chk("rm5_stall", 32'(bus.stall_o), 32'd0);
        ack_hold = 1'b0;
        force_ack = 1'b1;
        cyc(); smp();
        chk("rm6_req", 32'(bus.mem_req_o), 32'd0);
        cyc(); force_ack = 1'b0;
        repeat (4) cyc();
        smp();
        chk("rm7_req",   32'(bus.mem_req_o), 32'd0);
        chk("rm7_count", 32'(bus.count_o), 32'd0);
        chk("rm7_nwr",   32'(wr_log.size()), 32'(n0));
        chk("rm7_mem",   mem[8'h40], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_write_buffer.md
# dmem_write_buffer

Posted-write buffer and data-memory port controller for the MEM stage of the 5-stage pipelined CPU. It takes the MEM-stage memory request (MemRead/MemWrite, address, store data) from the EX/MEM register. Stores are queued in a small FIFO and the pipeline keeps running. Loads are served from the youngest matching queued store, or from a handshaked backing memory while the pipeline stalls; the buffer drains to that memory in the background.

## Interface
- DEPTH, 4, number of write-buffer entries (power of two, ≥2)
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- MemRead_i  in  1  MEM-stage load request
- MemWrite_i  in  1  MEM-stage store request
- addr_i  in  32  byte address; word compare on addr_i[31:2]
- data_i  in  32  store data
- data_o  out  32  load data to MEM/WB
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB this cycle
- mem_req_o  out  1  backing-memory request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  32  {addr[31:2],2'b00}
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  read data, valid with mem_ack_i
- mem_ack_i  in  1  request complete (may be same cycle as mem_req_o)
- count_o  out  log2(DEPTH)+1  occupied entries
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0

## Operation
- FIFO: circular, head/tail pointers wrap modulo DEPTH. Each entry holds word address [31:2] and data. count_o, full_o, and empty_o are registered.
- Store when !full_o: enqueued at the edge. stall_o=0.
- Store when full_o: stall_o=1. The store is enqueued at the first edge where full_o is 0 beforehand.
- Stores to an address already queued are enqueued as new entries; no merging.
- Load hit: any valid entry matches addr_i[31:2]. data_o = youngest matching entry's data, combinationally. stall_o=0. No memory access.
- Load miss: stall_o=1 until the RDONE cycle.
- Both MemRead_i and MemWrite_i high: treated as a load; the store is dropped.
- FSM states:
  - IDLE: mem_req_o=0. Load miss pending → RD. Else !empty_o → WR. Else stay.
  - WR: mem_req_o=1, mem_we_o=1, head entry on mem_addr_o/mem_wdata_o.
    - On mem_ack_i: pop head, → IDLE.
  - RD: mem_req_o=1, mem_we_o=0, mem_addr_o from addr_i.
    - On mem_ack_i: capture mem_rdata_i into rdata_q, → RDONE.
  - RDONE: stall_o=0, data_o=rdata_q, → IDLE.
- A request is never withdrawn. mem_req_o, address, and wdata stay stable from assertion until ack.
- A load miss arriving during WR waits for that ack, then takes priority over further drains.
- A load never waits for the buffer to drain, because a miss means there is no address conflict.
- Simultaneous enqueue and pop: count unchanged, both pointers advance.
- data_o with no load active = rdata_q.
- mem_ack_i in IDLE or RDONE is ignored.
- Reset (rst_i=0 at an edge):
  - pointers/count → 0, FSM → IDLE, rdata_q → 0.
  - Queued stores are discarded and any in-flight request is abandoned. An ack arriving after reset is ignored.
- Reset values: data_o=0, stall_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, count_o=0, full_o=0, empty_o=1.

## Timing
- Store accept latency 0 cycles when not full.
- Drain: entry enqueued at edge N; FSM enters WR at edge N+1; mem_req_o high in cycle N+1. With a zero-wait ack, the pop happens at edge N+2.
- Drain throughput with zero-wait memory: one entry per 2 cycles (WR→IDLE bubble).
- Load miss, FSM idle, zero-wait memory: stall_o high 2 cycles (IDLE, RD); data_o valid in the 3rd cycle (RDONE).
- Each memory wait cycle adds 1 cycle of stall.
- Load miss during WR: add the remaining WR cycles, including the ack cycle.
- Store-while-full, ack at cycle a: pop at edge a+1; full_o=0 in cycle a+1, store enqueued at edge a+2; stall_o high through cycle a.

## Test plan
- Reset: hold rst_i=0 2 cycles → all outputs at reset values, empty_o=1, count_o=0.
- Posted stores: 4 stores (0x10←0xA, 0x14←0xB, 0x18←0xC, 0x1C←0xD), memory ack delayed 3 cycles → stall_o stays 0, full_o=1 after the 4th store. Memory sees the writes in order 0x10, 0x14, 0x18, 0x1C.
- Full stall: 5th store to 0x20 while full → stall_o=1 until the first ack+1 cycle. 0x20 is written last; count_o never exceeds 4.
- Forwarding: store 0x40←0x1, then 0x40←0x2, then load 0x40 (ack held 0) → data_o=0x2 the same cycle, stall_o=0, no read request.
- Load miss: memory word 0x80=0xDEADBEEF, zero-wait ack, buffer empty → stall_o 2 cycles, data_o=0xDEADBEEF in the 3rd cycle, one read request.
- Reset mid-drain: 3 stores queued, assert rst_i during WR with ack low → next cycle mem_req_o=0, count_o=0. A later ack is ignored and no further writes are issued.
